// File: rtl/hilo_mdu_sequencer.sv
// Multi-cycle shift-add multiplier that owns the HI/LO pair and stalls the pipeline while busy.
// Supports mul, mult, multu, madd and msub, with Abort and mthi/mtlo writes that are honoured only in IDLE.
module hilo_mdu_sequencer #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [5:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Abort,
  input  logic             MtHi,
  input  logic             MtLo,
  input  logic [WIDTH-1:0] MtData,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  // state | meaning
  // IDLE  | waiting for a legal Start; mthi/mtlo accepted here
  // CALC  | N shift-add iterations on operand magnitudes
  // FIX   | sign correction and madd/msub accumulate against {Hi,Lo}
  // DONE  | Done pulse; commit to HI/LO (Result is already loaded for mul)
  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [5:0] OP_MUL   = 6'b000100;
  localparam logic [5:0] OP_MULT  = 6'b000101;
  localparam logic [5:0] OP_MULTU = 6'b000110;
  localparam logic [5:0] OP_MADD  = 6'b000111;
  localparam logic [5:0] OP_MSUB  = 6'b001000;

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_prod;
  logic               r_neg;
  logic [5:0]         r_op;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_result;

  logic               w_op_legal;
  logic               w_signed;
  logic               w_accept;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [2*WIDTH-1:0] w_partial;
  logic [2*WIDTH-1:0] w_signed_p;
  logic [2*WIDTH-1:0] w_fix;

  assign w_op_legal = (Op == OP_MUL) || (Op == OP_MULT) || (Op == OP_MULTU) ||
                      (Op == OP_MADD) || (Op == OP_MSUB);
  assign w_signed   = (Op != OP_MULTU);
  assign w_accept   = (r_state == S_IDLE) && Start && w_op_legal && !Abort;
  assign w_abs_a    = (w_signed && A[WIDTH-1]) ? -A : A;
  assign w_abs_b    = (w_signed && B[WIDTH-1]) ? -B : B;

  // Sum of the multiplicand copies selected by the low multiplier bits this cycle.
  always_comb begin
    w_partial = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (r_mplier[j]) w_partial = w_partial + (r_mcand << j);
    end
  end

  always_comb begin
    w_signed_p = r_neg ? -r_prod : r_prod;
    case (r_op)
      OP_MADD: w_fix = {r_hi, r_lo} + w_signed_p;
      OP_MSUB: w_fix = {r_hi, r_lo} - w_signed_p;
      default: w_fix = w_signed_p;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_neg    <= 1'b0;
      r_op     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (MtHi) r_hi <= MtData;
          if (MtLo) r_lo <= MtData;
          if (w_accept) begin
            r_state  <= S_CALC;
            r_cnt    <= CW'(N - 1);
            r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
            r_mplier <= w_abs_b;
            r_prod   <= '0;
            r_neg    <= w_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
            r_op     <= Op;
          end
        end
        S_CALC: begin
          if (Abort) begin
            r_state <= S_IDLE;
          end else begin
            r_prod   <= r_prod + w_partial;
            r_mcand  <= r_mcand << BITS_PER_CYCLE;
            r_mplier <= r_mplier >> BITS_PER_CYCLE;
            if (r_cnt == '0) r_state <= S_FIX;
            else             r_cnt   <= r_cnt - 1'b1;
          end
        end
        S_FIX: begin
          if (Abort) begin
            r_state <= S_IDLE;
          end else begin
            r_prod  <= w_fix;
            // mul result is loaded here so it is already valid during the Done pulse
            if (r_op == OP_MUL) r_result <= w_fix[WIDTH-1:0];
            r_state <= S_DONE;
          end
        end
        default: begin
          if (r_op != OP_MUL) begin
            r_hi <= r_prod[2*WIDTH-1:WIDTH];
            r_lo <= r_prod[WIDTH-1:0];
          end
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign Busy   = (r_state != S_IDLE);
  assign Done   = (r_state == S_DONE);
  assign Stall  = ((r_state == S_IDLE) && Start && w_op_legal) ||
                  (r_state == S_CALC) || (r_state == S_FIX);
  assign Result = r_result;
  assign Hi     = r_hi;
  assign Lo     = r_lo;

endmodule

// File: tb/tb_hilo_mdu_sequencer.sv
// Scoreboard bench for hilo_mdu_sequencer: expected HI/LO/Result are pushed at issue and popped on Done.
module tb_hilo_mdu_sequencer;
  localparam int W = 32;
  localparam int N = 32;

  localparam logic [5:0] OP_MUL   = 6'b000100;
  localparam logic [5:0] OP_MULT  = 6'b000101;
  localparam logic [5:0] OP_MULTU = 6'b000110;
  localparam logic [5:0] OP_MADD  = 6'b000111;
  localparam logic [5:0] OP_MSUB  = 6'b001000;

  logic         Clk = 1'b0;
  logic         Rst_n = 1'b0;
  logic         Start = 1'b0;
  logic [5:0]   Op = '0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Abort = 1'b0;
  logic         MtHi = 1'b0;
  logic         MtLo = 1'b0;
  logic [W-1:0] MtData = '0;
  logic         Busy, Stall, Done;
  logic [W-1:0] Result, Hi, Lo;

  hilo_mdu_sequencer #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Op(Op), .A(A), .B(B),
    .Abort(Abort), .MtHi(MtHi), .MtLo(MtLo), .MtData(MtData),
    .Busy(Busy), .Stall(Stall), .Done(Done), .Result(Result), .Hi(Hi), .Lo(Lo)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [5:0]   op;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W-1:0] res;
  } exp_t;

  exp_t         sb_q[$];
  int           n_chk = 0;
  int           n_pass = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic [W-1:0] m_res = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] model(input logic [5:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b, input logic [W-1:0] hi,
                                        input logic [W-1:0] lo);
    logic signed [63:0] sa, sb;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    if (op == OP_MULTU) p = {32'b0, a} * {32'b0, b};
    else                p = sa * sb;
    if (op == OP_MADD) p = {hi, lo} + p;
    if (op == OP_MSUB) p = {hi, lo} - p;
    return p;
  endfunction

  task automatic mt_write(input logic hi_en, input logic lo_en, input logic [W-1:0] d);
    MtHi = hi_en; MtLo = lo_en; MtData = d;
    @(posedge Clk); #1;
    MtHi = 1'b0; MtLo = 1'b0;
    if (hi_en) m_hi = d;
    if (lo_en) m_lo = d;
    chk("mt_hi", 64'(Hi), 64'(m_hi));
    chk("mt_lo", 64'(Lo), 64'(m_lo));
  endtask

  task automatic run_op(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit repulse, input bit mtlo_en, input logic [W-1:0] mtlo_d);
    exp_t e, got;
    logic [63:0] p;
    int cyc, stalls;
    bit seen;
    if (mtlo_en) m_lo = mtlo_d;
    p = model(op, a, b, m_hi, m_lo);
    e.op = op;
    if (op == OP_MUL) begin
      e.hi = m_hi; e.lo = m_lo; e.res = p[31:0];
    end else begin
      e.hi = p[63:32]; e.lo = p[31:0]; e.res = m_res;
    end
    sb_q.push_back(e);
    Op = op; A = a; B = b; Start = 1'b1; MtLo = mtlo_en; MtData = mtlo_d;
    cyc = 0; stalls = 0; seen = 0;
    while (cyc < 200) begin
      @(negedge Clk);
      if (Done) begin
        seen = 1;
        break;
      end
      if (Stall) stalls++;
      @(posedge Clk); #1;
      Start = repulse && (cyc == 4);
      MtLo = 1'b0;
      cyc++;
    end
    got = sb_q.pop_front();
    if (!seen) begin
      chk("done_timeout", 64'(seen), 64'(1));
      return;
    end
    chk("latency", 64'(cyc), 64'(N + 2));
    chk("stall_cycles", 64'(stalls), 64'(N + 2));
    chk("stall_in_done", 64'(Stall), 64'(0));
    if (got.op == OP_MUL) begin
      chk("result_in_done", 64'(Result), 64'(got.res));
      chk("hi_unchanged_mul", 64'(Hi), 64'(got.hi));
    end
    m_res = got.res;
    @(posedge Clk); #1;
    chk("hi", 64'(Hi), 64'(got.hi));
    chk("lo", 64'(Lo), 64'(got.lo));
    chk("result_hold", 64'(Result), 64'(m_res));
    chk("busy_after", 64'(Busy), 64'(0));
    m_hi = got.hi; m_lo = got.lo;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dn;
    logic [5:0] ops[5];
    ops[0] = OP_MUL; ops[1] = OP_MULT; ops[2] = OP_MULTU; ops[3] = OP_MADD; ops[4] = OP_MSUB;

    repeat (2) @(posedge Clk);
    #1;
    chk("rst_busy", 64'(Busy), 64'(0));
    chk("rst_stall", 64'(Stall), 64'(0));
    chk("rst_done", 64'(Done), 64'(0));
    chk("rst_hi", 64'(Hi), 64'(0));
    chk("rst_lo", 64'(Lo), 64'(0));
    chk("rst_result", 64'(Result), 64'(0));
    Rst_n = 1'b1;
    @(posedge Clk); #1;

    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 0, 0, '0);
    chk("mult_neg_hi", 64'(Hi), 64'hFFFF_FFFF);
    chk("mult_neg_lo", 64'(Lo), 64'hFFFF_FFF1);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, '0);
    chk("multu_max", {32'(Hi), 32'(Lo)}, 64'hFFFF_FFFE_0000_0001);
    run_op(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, '0);
    chk("mult_m1", {32'(Hi), 32'(Lo)}, 64'h0000_0000_0000_0001);

    mt_write(1, 0, 32'd0);
    mt_write(0, 1, 32'd10);
    run_op(OP_MADD, 32'd2, 32'd3, 0, 0, '0);
    chk("madd_lo", 64'(Lo), 64'd16);
    run_op(OP_MSUB, 32'd2, 32'd3, 0, 0, '0);
    chk("msub_lo", 64'(Lo), 64'd10);
    chk("msub_hi", 64'(Hi), 64'd0);
    mt_write(0, 1, 32'd0);
    run_op(OP_MSUB, 32'd1, 32'd1, 0, 0, '0);
    chk("msub_wrap", {32'(Hi), 32'(Lo)}, 64'hFFFF_FFFF_FFFF_FFFF);

    mt_write(1, 0, 32'hAAAA_5555);
    run_op(OP_MUL, 32'd7, 32'd6, 1, 0, '0);
    chk("mul_result", 64'(Result), 64'h2A);
    chk("mul_hi_kept", 64'(Hi), 64'hAAAA_5555);

    Op = 6'b000000; A = 32'd9; B = 32'd9; Start = 1'b1;
    @(negedge Clk);
    chk("illegal_stall", 64'(Stall), 64'(0));
    @(posedge Clk); #1;
    Start = 1'b0;
    chk("illegal_busy", 64'(Busy), 64'(0));

    Op = OP_MULT; Start = 1'b1; Abort = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0; Abort = 1'b0;
    chk("abort_blocks_accept", 64'(Busy), 64'(0));

    Op = OP_MULT; A = 32'd1234; B = 32'd5678; Start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge Clk); #1;
      Start = 1'b0;
      MtLo = (c == 5);
      MtData = 32'hDEAD_BEEF;
    end
    Abort = 1'b1;
    @(posedge Clk); #1;
    Abort = 1'b0;
    chk("abort_busy", 64'(Busy), 64'(0));
    chk("abort_stall", 64'(Stall), 64'(0));
    dn = 0;
    repeat (40) begin
      @(negedge Clk);
      if (Done) dn++;
    end
    @(posedge Clk); #1;
    chk("abort_no_done", 64'(dn), 64'(0));
    chk("abort_hi", 64'(Hi), 64'(m_hi));
    chk("abort_lo", 64'(Lo), 64'(m_lo));

    run_op(OP_MADD, 32'd2, 32'd3, 0, 1, 32'd100);
    chk("madd_mt_same_cycle", 64'(Lo), 64'd106);

    Op = OP_MULT; A = 32'd77; B = 32'd88; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
    Rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(Busy), 64'(0));
    chk("midrst_stall", 64'(Stall), 64'(0));
    chk("midrst_done", 64'(Done), 64'(0));
    chk("midrst_hilo", {32'(Hi), 32'(Lo)}, 64'(0));
    chk("midrst_result", 64'(Result), 64'(0));
    m_hi = '0; m_lo = '0; m_res = '0;
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    @(posedge Clk); #1;
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 0, 0, '0);

    for (int i = 0; i < 6; i++) begin
      run_op(ops[$urandom_range(0, 4)], $urandom, $urandom, 0, 0, '0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
